// File: rtl/tia_audio_if.sv
// Register-access bus for tia_audio: one-cycle strobe in, registered ack and read data out.
interface tia_audio_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) ();
  logic                  stb_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] adr_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  ack_o;

  modport master (output stb_i, we_i, adr_i, dat_i, input dat_o, ack_o);
  modport slave  (input stb_i, we_i, adr_i, dat_i, output dat_o, ack_o);
endinterface

// File: rtl/tia_audio.sv
// TIA-style sound generator: per-channel divider and polynomial counters,
// registered level/mix outputs and a PWM rendering of the mix.
module tia_audio #(
  parameter  int NUM_CH     = 2,
  parameter  int ADDR_WIDTH = 5,
  parameter  int DATA_WIDTH = 8,
  localparam int MIX_W      = $clog2(15*NUM_CH+1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  tia_audio_if.slave          bus,
  output logic [4*NUM_CH-1:0] level_o,
  output logic [MIX_W-1:0]    mix_o,
  output logic                pwm_o
);
  localparam int CH_W = ADDR_WIDTH - 2;

  logic [3:0] audc_q [NUM_CH], audc_d [NUM_CH];
  logic [4:0] audf_q [NUM_CH], audf_d [NUM_CH];
  logic [3:0] audv_q [NUM_CH], audv_d [NUM_CH];
  logic [4:0] div_q  [NUM_CH], div_d  [NUM_CH];
  logic [5:0] phase_q[NUM_CH], phase_d[NUM_CH];
  logic [3:0] p4_q   [NUM_CH], p4_d   [NUM_CH];
  logic [4:0] p5_q   [NUM_CH], p5_d   [NUM_CH];
  logic [8:0] p9_q   [NUM_CH], p9_d   [NUM_CH];
  logic       out_q  [NUM_CH], out_d  [NUM_CH];

  logic [4*NUM_CH-1:0]   level_q, level_d;
  logic [MIX_W-1:0]      mix_q, mix_d, cnt_q, cnt_d;
  logic                  pwm_q, pwm_d, ack_q, ack_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d, rdata;

  logic [CH_W-1:0] ch_sel;
  logic [1:0]      off_sel;
  logic            hit, wr, rd;
  logic            unused_dat;

  assign ch_sel     = bus.adr_i[ADDR_WIDTH-1:2];
  assign off_sel    = bus.adr_i[1:0];
  assign hit        = (int'(ch_sel) < NUM_CH) && (off_sel != 2'd3);
  assign wr         = bus.stb_i && bus.we_i && hit;
  assign rd         = bus.stb_i && !bus.we_i;
  assign unused_dat = ^bus.dat_i[DATA_WIDTH-1:5];

  function automatic logic [3:0] step4(input logic [3:0] p);
    return {p[2:0], p[3] ^ p[2]};
  endfunction
  function automatic logic [4:0] step5(input logic [4:0] p);
    return {p[3:0], p[4] ^ p[2]};
  endfunction
  function automatic logic [8:0] step9(input logic [8:0] p);
    return {p[7:0], p[8] ^ p[4]};
  endfunction

  always_comb begin
    rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (hit && ch_sel == CH_W'(c)) begin
        case (off_sel)
          2'd0:    rdata = DATA_WIDTH'(audc_q[c]);
          2'd1:    rdata = DATA_WIDTH'(audf_q[c]);
          2'd2:    rdata = DATA_WIDTH'(audv_q[c]);
          default: rdata = '0;
        endcase
      end
    end
  end

  always_comb begin
    logic       tick, wrap;
    logic [5:0] ph_max, ph_next;
    level_d = '0;
    mix_d   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      // NOTE: every next-state value starts from its current value, so no path can infer a latch.
      audc_d[c]  = audc_q[c];
      audf_d[c]  = audf_q[c];
      audv_d[c]  = audv_q[c];
      div_d[c]   = div_q[c];
      phase_d[c] = phase_q[c];
      p4_d[c]    = p4_q[c];
      p5_d[c]    = p5_q[c];
      p9_d[c]    = p9_q[c];
      out_d[c]   = out_q[c];
      tick       = 1'b0;

      if (enable_i) begin
        if (div_q[c] >= audf_q[c]) begin
          div_d[c] = '0;
          tick     = 1'b1;
        end else begin
          div_d[c] = div_q[c] + 5'd1;
        end
      end

      // Phase modulus for the phase-counting modes: 15, 46, otherwise 3.
      case (audc_q[c])
        4'd2, 4'd6, 4'd10: ph_max = 6'd14;
        4'd14:             ph_max = 6'd45;
        default:           ph_max = 6'd2;
      endcase
      wrap    = phase_q[c] >= ph_max;
      ph_next = wrap ? 6'd0 : phase_q[c] + 6'd1;

      if (tick) begin
        case (audc_q[c])
          4'd0, 4'd11: out_d[c] = 1'b1;
          4'd1: begin
            p4_d[c]  = step4(p4_q[c]);
            out_d[c] = p4_d[c][3];
          end
          4'd2: begin
            phase_d[c] = ph_next;
            if (wrap) p4_d[c] = step4(p4_q[c]);
            out_d[c] = p4_d[c][3];
          end
          4'd3: begin
            p5_d[c] = step5(p5_q[c]);
            if (p5_d[c][4]) p4_d[c] = step4(p4_q[c]);
            out_d[c] = p4_d[c][3];
          end
          4'd4, 4'd5: out_d[c] = !out_q[c];
          4'd7, 4'd9: begin
            p5_d[c]  = step5(p5_q[c]);
            out_d[c] = p5_d[c][4];
          end
          4'd8: begin
            p9_d[c]  = step9(p9_q[c]);
            out_d[c] = p9_d[c][8];
          end
          4'd15: begin
            phase_d[c] = ph_next;
            if (wrap) begin
              p5_d[c]  = step5(p5_q[c]);
              out_d[c] = p5_d[c][4];
            end
          end
          default: begin
            phase_d[c] = ph_next;
            if (wrap) out_d[c] = !out_q[c];
          end
        endcase
      end

      // Register writes win over the tick for div/phase; the tick itself saw the old values.
      if (wr && ch_sel == CH_W'(c)) begin
        case (off_sel)
          2'd0: begin
            audc_d[c]  = bus.dat_i[3:0];
            div_d[c]   = '0;
            phase_d[c] = '0;
          end
          2'd1:    audf_d[c] = bus.dat_i[4:0];
          2'd2:    audv_d[c] = bus.dat_i[3:0];
          default: ;
        endcase
      end

      level_d[4*c +: 4] = out_q[c] ? audv_q[c] : 4'd0;
      mix_d             = mix_d + MIX_W'(level_q[4*c +: 4]);
    end
  end

  assign cnt_d  = (cnt_q == MIX_W'(15*NUM_CH-1)) ? '0 : cnt_q + 1'b1;
  assign pwm_d  = cnt_q < mix_q;
  assign ack_d  = bus.stb_i;
  assign rdat_d = rd ? rdata : rdat_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        audc_q[c]  <= '0;
        audf_q[c]  <= '0;
        audv_q[c]  <= '0;
        div_q[c]   <= '0;
        phase_q[c] <= '0;
        p4_q[c]    <= 4'hF;
        p5_q[c]    <= 5'h1F;
        p9_q[c]    <= 9'h1FF;
        out_q[c]   <= 1'b0;
      end
      level_q <= '0;
      mix_q   <= '0;
      cnt_q   <= '0;
      pwm_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        audc_q[c]  <= audc_d[c];
        audf_q[c]  <= audf_d[c];
        audv_q[c]  <= audv_d[c];
        div_q[c]   <= div_d[c];
        phase_q[c] <= phase_d[c];
        p4_q[c]    <= p4_d[c];
        p5_q[c]    <= p5_d[c];
        p9_q[c]    <= p9_d[c];
        out_q[c]   <= out_d[c];
      end
      level_q <= level_d;
      mix_q   <= mix_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
    end
  end

  assign level_o    = level_q;
  assign mix_o      = mix_q;
  assign pwm_o      = pwm_q;
  assign bus.ack_o  = ack_q;
  assign bus.dat_o  = rdat_q;
endmodule

// File: doc/tia_audio.md
TIA_AUDIO -- requirements
Module: tia_audio

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, giving the number of independent sound channels (1..8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, giving the register address width; 4*NUM_CH SHALL NOT exceed 2^ADDR_WIDTH.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 8, giving the register data width.
REQ-004 Derived width MIX_W SHALL be the minimum width able to hold 15*NUM_CH.
REQ-005 clk_i  in  1  system clock; sole clock.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 enable_i  in  1  audio-rate tick strobe, one clk_i cycle wide.
REQ-008 stb_i  in  1  register access strobe.
REQ-009 we_i  in  1  1 = write, 0 = read.
REQ-010 adr_i  in  ADDR_WIDTH  register address.
REQ-011 dat_i  in  DATA_WIDTH  write data.
REQ-012 dat_o  out  DATA_WIDTH  read data.
REQ-013 ack_o  out  1  access acknowledge.
REQ-014 level_o  out  4*NUM_CH  per-channel level; channel c at bits [4c+3:4c].
REQ-015 mix_o  out  MIX_W  sum of all channel levels.
REQ-016 pwm_o  out  1  pulse-width-modulated mix.

Function
REQ-017 The register map SHALL be: channel c base 4c; offset 0 AUDC[3:0], offset 1 AUDF[4:0], offset 2 AUDV[3:0], offset 3 reserved.
REQ-018 Writes to offset 3 or to channel index >= NUM_CH SHALL be ignored; reads of those SHALL return 0.
REQ-019 A write SHALL update the register on the clk_i edge where stb_i=1 and we_i=1; unused upper dat_i bits SHALL be discarded.
REQ-020 A read SHALL load dat_o with the zero-extended register value on the edge where stb_i=1 and we_i=0.
REQ-021 ack_o SHALL be high for exactly one cycle, the cycle after each stb_i cycle; back-to-back strobes SHALL each get one ack.
REQ-022 Each channel SHALL have a 5-bit divider: on enable_i, if div >= AUDF then div <= 0 and a channel tick fires, else div <= div+1.
REQ-023 Lowering AUDF below the current div SHALL cause a wrap and tick on the next enable_i.
REQ-024 Each channel SHALL have poly4 (reset 4'hF, step {p[2:0],p[3]^p[2]}), poly5 (reset 5'h1F, step {p[3:0],p[4]^p[2]}), poly9 (reset 9'h1FF, step {p[7:0],p[8]^p[4]}), a 6-bit phase counter, and an output bit out (reset 0).
REQ-025 Mode handling on each channel tick SHALL follow AUDC:
- 0, 11: out <= 1.
- 1: step poly4; out <= new poly4[3].
- 2: phase counter mod 15; on wrap step poly4; out <= poly4[3].
- 3: step poly5; if new poly5[4]=1 step poly4; out <= poly4[3].
- 4, 5: toggle out.
- 6, 10: phase mod 15; toggle out on wrap.
- 7, 9: step poly5; out <= new poly5[4].
- 8: step poly9; out <= new poly9[8].
- 12, 13: phase mod 3; toggle out on wrap.
- 14: phase mod 46; toggle out on wrap.
- 15: phase mod 3; on wrap step poly5 and out <= new poly5[4].
REQ-026 "Phase mod K" SHALL mean: if phase >= K-1 then phase <= 0 (wrap) else phase <= phase+1.
REQ-027 A write to AUDC SHALL clear that channel's phase and div the next cycle; poly registers and out SHALL be retained.
REQ-028 If a register write and a channel tick coincide, the tick SHALL use the pre-write register values.
REQ-029 level_o for channel c SHALL be registered: out ? AUDV : 0, updated every clk_i cycle.
REQ-030 AUDV=0 SHALL force level 0 while generators keep running.
REQ-031 mix_o SHALL be the registered sum of all level_o fields, one cycle after level_o.
REQ-032 A pwm counter SHALL count 0..15*NUM_CH-1 every clk_i cycle and wrap; pwm_o SHALL be registered (counter < mix_o).
REQ-033 mix_o = 15*NUM_CH SHALL give constant pwm_o=1; mix_o = 0 SHALL give constant 0.

Reset
REQ-034 When rst_i=1, all registers SHALL clear to 0, except the poly registers, which SHALL load the REQ-024 reset values.
REQ-035 During reset, dat_o, ack_o, level_o, mix_o and pwm_o SHALL be 0.
REQ-036 Reset SHALL override any same-cycle access or tick.
REQ-037 Reset mid-access SHALL suppress the pending ack_o.

Verification
REQ-038 Ch0 AUDC=4, AUDF=0, AUDV=15; enable_i every cycle -> level_o[3:0] alternates 15/0 each cycle after first tick; mix_o follows one cycle later.
REQ-039 AUDC=1, AUDF=0 -> out sequence repeats with period 15 ticks, starting 1,1,1,0 from reset poly4.
REQ-040 AUDF=31 then write AUDF=2 while div=20 -> tick on next enable_i, then every 3 enables.
REQ-041 NUM_CH=2, both AUDC=0, AUDV=15 -> mix_o=30, pwm_o constant 1; ch1 AUDV=0 -> mix_o=15, pwm_o high 15 of every 30 cycles.
REQ-042 Write ch1 AUDF=0x1A, read back -> dat_o=0x1A; ack_o one cycle after each strobe; read adr 3 or 8 -> 0.
REQ-043 Assert rst_i mid-tone with a strobe in flight -> all outputs 0 next cycle, no ack, poly registers at reset values.
